// File: rtl/systolic_result_collector_pkg.sv
// -----------------------------------------------------------------------------
// systolic_result_collector_pkg
// Shared constants and helpers for the systolic array drain path:
//   - requantization shift and output clamp limits
//   - parameter consistency check
//   - column field layout of the packed down-going PSUM bus
// No ports (package).
// -----------------------------------------------------------------------------
package systolic_result_collector_pkg;

   // Default geometry of the array drain.
   localparam int DEF_PE_NUMBER           = 4;
   localparam int DEF_PSUM_WIDTH          = 32;
   localparam int DEF_PSUM_FRACTIONAL     = 24;
   localparam int DEF_OUT_WIDTH           = 16;
   localparam int DEF_OUT_FRACTIONAL      = 12;

   // Right shift that moves a PSUM onto the output fixed-point grid.
   function automatic int calc_shift(input int psum_frac, input int out_frac);
      return psum_frac - out_frac;
   endfunction

   // Largest representable output value.
   function automatic longint out_max(input int out_width, input bit is_unsigned);
      return is_unsigned ? ((longint'(1) << out_width) - 1)
                         : ((longint'(1) << (out_width - 1)) - 1);
   endfunction

   // Smallest representable output value.
   function automatic longint out_min(input int out_width, input bit is_unsigned);
      return is_unsigned ? longint'(0) : -(longint'(1) << (out_width - 1));
   endfunction

   // The rounding datapath is PSUM_WIDTH+1 bits wide, so the output must not
   // be wider than the PSUM and the output cannot carry more fraction bits.
   function automatic bit widths_ok(input int pe_number, input int psum_width,
                                    input int psum_frac, input int out_width,
                                    input int out_frac);
      return (pe_number >= 1) && (out_width >= 1) && (out_width <= psum_width) &&
             (out_frac <= psum_frac) && (out_width < 63);
   endfunction

   // Column c of the packed input bus starts at this bit.
   function automatic int col_lsb(input int col, input int psum_width);
      return col * psum_width;
   endfunction

endpackage : systolic_result_collector_pkg

// File: rtl/psum_requantizer.sv
// -----------------------------------------------------------------------------
// psum_requantizer
// Combinational requantizer: round-half-up, shift to the output fraction,
// clamp to the output range.
//   psum_i  in  PSUM_WIDTH  partial sum (signed unless IS_UNSIGNED)
//   data_o  out OUT_WIDTH   requantized, saturated value
//   sat_o   out 1           clamp engaged for this value
// -----------------------------------------------------------------------------
module psum_requantizer
   import systolic_result_collector_pkg::*;
#(
   parameter int PSUM_WIDTH           = DEF_PSUM_WIDTH,
   parameter int PSUM_FRACTIONAL_BITS = DEF_PSUM_FRACTIONAL,
   parameter int OUT_WIDTH            = DEF_OUT_WIDTH,
   parameter int OUT_FRACTIONAL_BITS  = DEF_OUT_FRACTIONAL,
   parameter bit IS_UNSIGNED          = 1'b0
) (
   input  logic [PSUM_WIDTH-1:0] psum_i,
   output logic [OUT_WIDTH-1:0]  data_o,
   output logic                  sat_o
);

   // One guard bit above the PSUM keeps the rounding add from wrapping.
   localparam int W       = PSUM_WIDTH + 1;
   localparam int SHIFT   = calc_shift(PSUM_FRACTIONAL_BITS, OUT_FRACTIONAL_BITS);
   localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic [W-1:0] RND    = (SHIFT > 0) ? (W'(1) << RND_POS) : '0;
   localparam logic [W-1:0] LIM_HI = W'(out_max(OUT_WIDTH, IS_UNSIGNED));
   localparam logic [W-1:0] LIM_LO = W'(out_min(OUT_WIDTH, IS_UNSIGNED));

   logic [W-1:0] ext;
   logic [W-1:0] sum;
   logic [W-1:0] shifted;

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the if/else leaves a value unassigned and infers a latch.
   always_comb begin
      ext     = IS_UNSIGNED ? {1'b0, psum_i} : {psum_i[PSUM_WIDTH-1], psum_i};
      sum     = ext + RND;
      shifted = sum >> SHIFT;
      data_o  = shifted[OUT_WIDTH-1:0];
      sat_o   = 1'b0;

      if (IS_UNSIGNED) begin
         if (shifted > LIM_HI) begin
            data_o = LIM_HI[OUT_WIDTH-1:0];
            sat_o  = 1'b1;
         end
      end else begin
         // Separate statement keeps the shift arithmetic (signedness of the
         // right-hand side is not influenced by the target).
         shifted = $signed(sum) >>> SHIFT;
         data_o  = shifted[OUT_WIDTH-1:0];
         if ($signed(shifted) > $signed(LIM_HI)) begin
            data_o = LIM_HI[OUT_WIDTH-1:0];
            sat_o  = 1'b1;
         end else if ($signed(shifted) < $signed(LIM_LO)) begin
            data_o = LIM_LO[OUT_WIDTH-1:0];
            sat_o  = 1'b1;
         end
      end
   end

endmodule : psum_requantizer

// File: rtl/systolic_result_collector.sv
// -----------------------------------------------------------------------------
// systolic_result_collector
// Drain end of the systolic array. Serializes the PE_NUMBER_I column streams
// column-interleaved (c0, c1, ..., cN-1, c0, ...) into one AXI-Stream,
// requantizing every PSUM, and checks that all columns frame with aligned tlast.
//   clk, rst                 clock, asynchronous active-low reset
//   s_axis_d_tdata/tvalid/tready/tlast  per-column input streams
//   m_axis_tdata/tvalid/tready/tlast    serialized, requantized output
//   err_unalligned_data      sticky: a column's tlast disagreed with column 0
//   err_saturation           one-cycle pulse when a saturated beat is presented
// -----------------------------------------------------------------------------
module systolic_result_collector
   import systolic_result_collector_pkg::*;
#(
   parameter int PE_NUMBER_I          = DEF_PE_NUMBER,
   parameter int PSUM_WIDTH           = DEF_PSUM_WIDTH,
   parameter int PSUM_FRACTIONAL_BITS = DEF_PSUM_FRACTIONAL,
   parameter int OUT_WIDTH            = DEF_OUT_WIDTH,
   parameter int OUT_FRACTIONAL_BITS  = DEF_OUT_FRACTIONAL,
   parameter bit IS_UNSIGNED          = 1'b0
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [PE_NUMBER_I*PSUM_WIDTH-1:0] s_axis_d_tdata,
   input  logic [PE_NUMBER_I-1:0]            s_axis_d_tvalid,
   output logic [PE_NUMBER_I-1:0]            s_axis_d_tready,
   input  logic [PE_NUMBER_I-1:0]            s_axis_d_tlast,
   output logic [OUT_WIDTH-1:0]              m_axis_tdata,
   output logic                              m_axis_tvalid,
   input  logic                              m_axis_tready,
   output logic                              m_axis_tlast,
   output logic                              err_unalligned_data,
   output logic                              err_saturation
);

   localparam int SEL_W = (PE_NUMBER_I > 1) ? $clog2(PE_NUMBER_I) : 1;
   localparam logic [SEL_W-1:0] LAST_COL = SEL_W'(PE_NUMBER_I - 1);

   generate
      if (!widths_ok(PE_NUMBER_I, PSUM_WIDTH, PSUM_FRACTIONAL_BITS,
                     OUT_WIDTH, OUT_FRACTIONAL_BITS)) begin : g_bad_params
         $error("systolic_result_collector: inconsistent width parameters");
      end
   endgenerate

   logic [SEL_W-1:0]     sel_q, sel_d;
   logic                 run_q;           // low until the first edge after reset
   logic                 round_last_q;
   logic                 err_unal_q;
   logic                 err_sat_q;
   logic                 m_tvalid_q;
   logic                 m_tlast_q;
   logic [OUT_WIDTH-1:0] m_tdata_q;

   logic                  take;           // output register can load this cycle
   logic                  accept;
   logic                  valid_sel;
   logic                  tlast_sel;
   logic [PSUM_WIDTH-1:0] psum_sel;
   logic [OUT_WIDTH-1:0]  q_data;
   logic                  q_sat;

   // Column mux and ready steering: only the selected column sees ready.
   always_comb begin
      take            = run_q & (~m_tvalid_q | m_axis_tready);
      s_axis_d_tready = '0;
      psum_sel        = '0;
      valid_sel       = 1'b0;
      tlast_sel       = 1'b0;
      for (int c = 0; c < PE_NUMBER_I; c++) begin
         if (sel_q == SEL_W'(c)) begin
            s_axis_d_tready[c] = take;
            psum_sel           = s_axis_d_tdata[col_lsb(c, PSUM_WIDTH) +: PSUM_WIDTH];
            valid_sel          = s_axis_d_tvalid[c];
            tlast_sel          = s_axis_d_tlast[c];
         end
      end
      accept = valid_sel & take;
      sel_d  = (sel_q == LAST_COL) ? '0 : sel_q + 1'b1;
   end

   psum_requantizer #(
      .PSUM_WIDTH           (PSUM_WIDTH),
      .PSUM_FRACTIONAL_BITS (PSUM_FRACTIONAL_BITS),
      .OUT_WIDTH            (OUT_WIDTH),
      .OUT_FRACTIONAL_BITS  (OUT_FRACTIONAL_BITS),
      .IS_UNSIGNED          (IS_UNSIGNED)
   ) u_requant (
      .psum_i (psum_sel),
      .data_o (q_data),
      .sat_o  (q_sat)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sel_q        <= '0;
         run_q        <= 1'b0;
         round_last_q <= 1'b0;
         err_unal_q   <= 1'b0;
         err_sat_q    <= 1'b0;
         m_tvalid_q   <= 1'b0;
         m_tlast_q    <= 1'b0;
         m_tdata_q    <= '0;
      end else begin
         run_q     <= 1'b1;
         err_sat_q <= 1'b0;        // pulse only on the cycle a beat is loaded
         if (accept) begin
            m_tvalid_q <= 1'b1;
            m_tdata_q  <= q_data;
            m_tlast_q  <= (sel_q == LAST_COL) & tlast_sel;
            err_sat_q  <= q_sat;
            sel_q      <= sel_d;
            // Column 0 sets the round's framing; the rest must agree with it.
            if (sel_q == '0) begin
               round_last_q <= tlast_sel;
            end else if (tlast_sel != round_last_q) begin
               err_unal_q <= 1'b1;
            end
         end else if (m_axis_tready) begin
            m_tvalid_q <= 1'b0;
         end
      end
   end

   assign m_axis_tdata        = m_tdata_q;
   assign m_axis_tvalid       = m_tvalid_q;
   assign m_axis_tlast        = m_tlast_q;
   assign err_unalligned_data = err_unal_q;
   assign err_saturation      = err_sat_q;

endmodule : systolic_result_collector

// File: tb/tb_systolic_result_collector.sv
// -----------------------------------------------------------------------------
// tb_systolic_result_collector
// Directed stimulus for the 4-column collector (Q8.24 -> Q4.12, signed).
// Per-column source queues feed a driver; expected output beats go into a
// scoreboard queue that an independent monitor pops on each output handshake.
// -----------------------------------------------------------------------------
module tb_systolic_result_collector;

   localparam int PE = 4;
   localparam int PW = 32;
   localparam int OW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [PE*PW-1:0] s_tdata  = '0;
   logic [PE-1:0]    s_tvalid = '0;
   logic [PE-1:0]    s_tready;
   logic [PE-1:0]    s_tlast  = '0;
   logic [OW-1:0]    m_tdata;
   logic             m_tvalid;
   logic             m_tready = 1'b1;
   logic             m_tlast;
   logic             err_unal;
   logic             err_sat;

   always #5 clk = ~clk;

   systolic_result_collector #(
      .PE_NUMBER_I          (PE),
      .PSUM_WIDTH           (PW),
      .PSUM_FRACTIONAL_BITS (24),
      .OUT_WIDTH            (OW),
      .OUT_FRACTIONAL_BITS  (12),
      .IS_UNSIGNED          (1'b0)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .s_axis_d_tdata      (s_tdata),
      .s_axis_d_tvalid     (s_tvalid),
      .s_axis_d_tready     (s_tready),
      .s_axis_d_tlast      (s_tlast),
      .m_axis_tdata        (m_tdata),
      .m_axis_tvalid       (m_tvalid),
      .m_axis_tready       (m_tready),
      .m_axis_tlast        (m_tlast),
      .err_unalligned_data (err_unal),
      .err_saturation      (err_sat)
   );

   typedef struct packed {
      logic [PW-1:0] data;
      logic          last;
   } src_beat_t;

   typedef struct packed {
      logic [OW-1:0] data;
      logic          last;
      logic          sat;
   } exp_beat_t;

   src_beat_t src_q [PE][$];
   exp_beat_t exp_q [$];
   int        hs_times [$];
   int        total   = 0;
   int        bad     = 0;
   int        cyc     = 0;
   int        acc_cnt = 0;
   bit        seen    = 1'b0;
   logic      sat_seen = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // One round: column c gets d[c], l[c]; expected output for column c is e[c], s[c].
   task automatic load_round(input logic [PE*PW-1:0] d, input logic [PE-1:0] l,
                             input logic [PE*OW-1:0] e, input logic [PE-1:0] s);
      for (int c = 0; c < PE; c++) begin
         src_q[c].push_back('{data: d[c*PW +: PW], last: l[c]});
         exp_q.push_back('{data: e[c*OW +: OW], last: (c == PE-1) && l[c], sat: s[c]});
      end
   endtask

   task automatic wait_drain(input string name);
      bit done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !m_tvalid) done = 1'b1;
      end
      check(name, exp_q.size(), 0);
   endtask

   // Driver: presents each column's head beat, pops it once it was accepted.
   initial begin : driver
      bit        hs [PE];
      src_beat_t b;
      forever begin
         @(negedge clk);
         for (int c = 0; c < PE; c++) hs[c] = s_tvalid[c] & s_tready[c];
         @(posedge clk);
         #1;
         for (int c = 0; c < PE; c++) begin
            if (hs[c] && rst && src_q[c].size() > 0) begin
               void'(src_q[c].pop_front());
               acc_cnt++;
            end
            if (src_q[c].size() > 0) begin
               b = src_q[c][0];
               s_tvalid[c]          = 1'b1;
               s_tdata[c*PW +: PW]  = b.data;
               s_tlast[c]           = b.last;
            end else begin
               s_tvalid[c] = 1'b0;
            end
         end
      end
   end

   // Monitor: saturation flag is captured when a beat first appears,
   // data/last are compared on the handshake.
   initial begin : monitor
      exp_beat_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            if (m_tvalid && !seen) begin
               seen     = 1'b1;
               sat_seen = err_sat;
            end
            if (m_tvalid && m_tready) begin
               hs_times.push_back(cyc);
               if (exp_q.size() == 0) begin
                  check("unexpected_beat", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("out_data", m_tdata, e.data);
                  check("out_last", m_tlast, e.last);
                  check("err_saturation", sat_seen, e.sat);
               end
               seen = 1'b0;
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : main
      bit            found;
      logic [OW-1:0] hold_data;
      logic          hold_last;

      // ---- reset state ----
      repeat (3) @(posedge clk);
      #1;
      check("rst_tvalid", m_tvalid, 0);
      check("rst_tdata", m_tdata, 0);
      check("rst_tlast", m_tlast, 0);
      check("rst_err_unal", err_unal, 0);
      check("rst_err_sat", err_sat, 0);
      check("rst_s_tready", s_tready, 4'b0000);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("release_s_tready", s_tready, 4'b0001);

      // ---- interleave: 2 beats per column, tlast on beat 2 ----
      hs_times.delete();
      load_round({32'h0000_4000, 32'h0000_3000, 32'h0000_2000, 32'h0000_1000}, 4'b0000,
                 {16'h0004, 16'h0003, 16'h0002, 16'h0001}, 4'b0000);
      load_round({32'h0000_8000, 32'h0000_7000, 32'h0000_6000, 32'h0000_5000}, 4'b1111,
                 {16'h0008, 16'h0007, 16'h0006, 16'h0005}, 4'b0000);
      wait_drain("interleave_drain");
      check("interleave_beats", hs_times.size(), 8);
      if (hs_times.size() == 8) check("interleave_span", hs_times[7] - hs_times[0], 7);

      // ---- rounding ----
      load_round({32'hFFFF_F800, 32'h0000_07FF, 32'h0000_0800, 32'h0180_0000}, 4'b0000,
                 {16'h0000, 16'h0000, 16'h0001, 16'h1800}, 4'b0000);
      // ---- saturation ----
      load_round({32'h0000_3000, 32'h07FF_F000, 32'h8000_0000, 32'h7FFF_FFFF}, 4'b1111,
                 {16'h0003, 16'h7FFF, 16'h8000, 16'h7FFF}, 4'b0011);
      wait_drain("round_sat_drain");
      check("aligned_no_err", err_unal, 0);

      // ---- backpressure ----
      hs_times.delete();
      load_round({32'h0000_D000, 32'h0000_C000, 32'h0000_B000, 32'h0000_A000}, 4'b0000,
                 {16'h000D, 16'h000C, 16'h000B, 16'h000A}, 4'b0000);
      load_round({32'h0001_1000, 32'h0001_0000, 32'h0000_F000, 32'h0000_E000}, 4'b1111,
                 {16'h0011, 16'h0010, 16'h000F, 16'h000E}, 4'b0000);
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         if (hs_times.size() >= 2) found = 1'b1;
      end
      check("bp_start", found, 1);
      @(posedge clk);
      #1;
      m_tready = 1'b0;
      hold_data = '0;
      hold_last = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 0) begin
            hold_data = m_tdata;
            hold_last = m_tlast;
         end
         check("bp_tvalid", m_tvalid, 1);
         check("bp_tdata_stable", m_tdata, hold_data);
         check("bp_tlast_stable", m_tlast, hold_last);
         check("bp_s_tready", s_tready, 4'b0000);
      end
      @(posedge clk);
      #1;
      m_tready = 1'b1;
      wait_drain("bp_drain");
      check("bp_beats", hs_times.size(), 8);

      // ---- misalignment: c0 tlast=0, c2 tlast=1 ----
      load_round({32'h0000_4000, 32'h0000_3000, 32'h0000_2000, 32'h0000_1000}, 4'b0100,
                 {16'h0004, 16'h0003, 16'h0002, 16'h0001}, 4'b0000);
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clk);
         if (s_tvalid[2] && s_tready[2]) begin
            found = 1'b1;
            check("unal_before", err_unal, 0);
            @(posedge clk);
            #1;
            check("unal_next_cycle", err_unal, 1);
         end
      end
      check("unal_c2_seen", found, 1);
      wait_drain("unal_drain");
      load_round({32'h0000_8000, 32'h0000_7000, 32'h0000_6000, 32'h0000_5000}, 4'b1111,
                 {16'h0008, 16'h0007, 16'h0006, 16'h0005}, 4'b0000);
      wait_drain("unal_sticky_drain");
      check("unal_sticky", err_unal, 1);

      // ---- reset mid-frame after 3 accepted beats ----
      acc_cnt = 0;
      load_round({32'h0000_4000, 32'h0000_3000, 32'h0000_2000, 32'h0000_1000}, 4'b0000,
                 {16'h0004, 16'h0003, 16'h0002, 16'h0001}, 4'b0000);
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(posedge clk);
         #2;
         if (acc_cnt >= 3) found = 1'b1;
      end
      check("midrst_three_accepted", acc_cnt, 3);
      rst = 1'b0;
      #1;
      check("midrst_tvalid", m_tvalid, 0);
      check("midrst_tdata", m_tdata, 0);
      check("midrst_tlast", m_tlast, 0);
      check("midrst_err_unal", err_unal, 0);
      check("midrst_err_sat", err_sat, 0);
      check("midrst_s_tready", s_tready, 4'b0000);
      exp_q.delete();
      for (int c = 0; c < PE; c++) src_q[c].delete();
      seen = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_release_tready", s_tready, 4'b0001);
      load_round({32'h0240_0000, 32'h0230_0000, 32'h0220_0000, 32'h0210_0000}, 4'b1111,
                 {16'h2400, 16'h2300, 16'h2200, 16'h2100}, 4'b0000);
      wait_drain("midrst_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_systolic_result_collector

// File: doc/systolic_result_collector.md
# systolic_result_collector

Drain end of the systolic processing array. Accepts the `PE_NUMBER_I` down-going partial-sum AXI-Streams leaving the bottom PE row and serializes them column-interleaved into one AXI-Stream. Requantizes each PSUM to the output fixed-point format with round-half-up and saturation. Checks that all columns frame their results with aligned `tlast`.

## Interface
- `PE_NUMBER_I`, 4, number of array columns / input streams (≥1)
- `PSUM_WIDTH`, 32, width of each input partial sum
- `PSUM_FRACTIONAL_BITS`, 24, fractional bits of input PSUM
- `OUT_WIDTH`, 16, output data width
- `OUT_FRACTIONAL_BITS`, 12, output fractional bits; must be ≤ `PSUM_FRACTIONAL_BITS`
- `IS_UNSIGNED`, 0, treat PSUM and output as unsigned
- `clk` in 1, single clock, rising edge
- `rst` in 1, reset, asynchronous, active-low
- `s_axis_d_tdata` in `PE_NUMBER_I*PSUM_WIDTH`, column c at bits `[c*PSUM_WIDTH +: PSUM_WIDTH]`
- `s_axis_d_tvalid` in `PE_NUMBER_I`, per-column valid
- `s_axis_d_tready` out `PE_NUMBER_I`, per-column ready
- `s_axis_d_tlast` in `PE_NUMBER_I`, per-column last
- `m_axis_tdata` out `OUT_WIDTH`, requantized result
- `m_axis_tvalid` out 1; `m_axis_tready` in 1; `m_axis_tlast` out 1
- `err_unalligned_data` out 1, sticky tlast-misalignment flag
- `err_saturation` out 1, one-cycle pulse per saturated beat

## Operation
- Column pointer `sel` in 0..`PE_NUMBER_I`-1. Only `s_axis_d_tready[sel]` may be high. All other readies are 0.
- A beat is accepted on column `sel` when its valid and ready are both high. After acceptance, `sel` increments and wraps from `PE_NUMBER_I`-1 to 0. One full wrap is one round.
- Round flag `round_last`:
  - Captured from `s_axis_d_tlast[0]` on the column-0 beat.
  - Each later column's tlast is compared against it. A mismatch sets `err_unalligned_data`. The flag stays set until reset.
- `m_axis_tlast` = `s_axis_d_tlast[PE_NUMBER_I-1]` on the column `PE_NUMBER_I`-1 beat. It is 0 on all other beats.
- Requantization, with SHIFT = `PSUM_FRACTIONAL_BITS`-`OUT_FRACTIONAL_BITS`:
  - If SHIFT>0: compute `(psum + 2^(SHIFT-1)) >>> SHIFT` at `PSUM_WIDTH`+1 bits, so the rounding add cannot wrap.
  - Saturate to the signed range [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], or to [0, 2^OUT_WIDTH-1] when `IS_UNSIGNED`.
  - `err_saturation` pulses when the clamp engages on an accepted beat.
- `PE_NUMBER_I`=1: `sel` stays at 0, and every beat is both column 0 and the last column.

## Timing
- Reset values:
  - `m_axis_tvalid`, `m_axis_tdata`, `m_axis_tlast` = 0.
  - `err_*` = 0; `sel` = 0.
  - `s_axis_d_tready` = 0 while `rst` is low. From the first edge after release, `s_axis_d_tready[0]` is 1.
- Single output register stage. `s_axis_d_tready[sel]` = `!m_axis_tvalid | m_axis_tready`.
- Latency: 1 cycle from input acceptance to `m_axis_tvalid`.
- Throughput: 1 beat/cycle under continuous ready.
- While `m_axis_tvalid`=1 and `m_axis_tready`=0, `m_axis_tdata` and `m_axis_tlast` are held stable. No input is accepted.
- If the selected column is not valid, the collector stalls on it. Other columns are never skipped.
- `err_saturation` is asserted in the same cycle the saturated beat first appears on `m_axis_tvalid`.
- `err_unalligned_data` rises the cycle after the mismatching beat is accepted.
- Reset mid-frame: all state is cleared asynchronously. The partial round and any held output are discarded. The next accepted beat is taken from column 0.

## Structure
- Shared package/header holds:
  - SHIFT, OUT_MAX, OUT_MIN derivation and the width-check constant.
  - The AXIS beat field layout shared with the array.
- One sub-module, `psum_requantizer`: combinational round/shift/saturate with a `sat` flag. The collector instantiates it between the column mux and the output register.
- Top level contains `sel`, `round_last`, the error flag, and the output register.

## Test plan
- **Interleave:** `PE_NUMBER_I`=4, 2 beats per column, tlast on beat 2 of every column, `m_axis_tready`=1.
  - Output order is c0b0,c1b0,c2b0,c3b0,c0b1,c1b1,c2b1,c3b1.
  - `m_axis_tlast` only on the 8th beat; 8 consecutive valid cycles.
- **Rounding (Q8.24→Q4.12):**
  - PSUM 0x0180_0000 → 0x1800.
  - 0x0000_0800 → 0x0001.
  - 0x0000_07FF → 0x0000.
  - 0xFFFF_F800 (−0.5 LSB) → 0x0000.
- **Saturation:**
  - 0x7FFF_FFFF → 0x7FFF with an `err_saturation` pulse.
  - 0x8000_0000 → 0x8000 with a pulse.
  - 0x07FF_F000 → 0x7FFF with no pulse.
- **Backpressure:** `m_axis_tready` held low 5 cycles mid-round.
  - tdata/tlast stable, all `s_axis_d_tready`=0.
  - All beats delivered in order after release, none lost or duplicated.
- **Misalignment:** column 0 tlast=0 while column 2 tlast=1 in the same round.
  - `err_unalligned_data` goes high the next cycle and stays high across later rounds until reset.
- **Reset mid-frame:** assert `rst` low after 3 accepted beats.
  - All outputs are immediately 0.
  - After release, the first accepted beat comes from column 0 and output ordering restarts at c0.
